// File: rtl/hdr_slice_serializer_if.sv
// Bus between the HDR engine, the slice mux and hdr_slice_serializer.
// The serializer connects through the slave modport; the engine/bench side uses master.
interface hdr_slice_serializer_if #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
);
  logic                 i_start;
  logic                 i_abort;
  logic [SEL-1:0]       i_first_sel;
  logic [SEL:0]         i_count;
  logic [BUS_WIDTH-1:0] i_slice;
  logic                 i_bit_ready;
  logic [SEL-1:0]       o_ctrl_sel;
  logic                 o_bit;
  logic                 o_bit_valid;
  logic                 o_busy;
  logic                 o_done;
  logic [1:0]           o_dbg_state;

  // Handshake: a bit transfers on a rising edge where o_bit_valid && i_bit_ready;
  // while o_bit_valid is high and i_bit_ready low, o_bit and o_ctrl_sel hold.
  modport slave (
    input  i_start, i_abort, i_first_sel, i_count, i_slice, i_bit_ready,
    output o_ctrl_sel, o_bit, o_bit_valid, o_busy, o_done, o_dbg_state
  );

  modport master (
    output i_start, i_abort, i_first_sel, i_count, i_slice, i_bit_ready,
    input  o_ctrl_sel, o_bit, o_bit_valid, o_busy, o_done, o_dbg_state
  );
endinterface

// File: rtl/hdr_slice_serializer.sv
// Walks the slice mux through a run of selects and streams each slice out bit-serially.
// Define HDR_SER_LSB_FIRST_EN to emit each slice LSB first (default MSB first).
module hdr_slice_serializer #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  hdr_slice_serializer_if.slave  sif
);
  localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [BUS_WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]        bit_cnt, bit_cnt_nx;
  logic [SEL:0]         rem, rem_nx;
  logic [SEL-1:0]       sel, sel_nx;
  logic                 head_bit;
  logic [BUS_WIDTH-1:0] shreg_adv;

`ifdef HDR_SER_LSB_FIRST_EN
  assign head_bit  = shreg[0];
  assign shreg_adv = shreg >> 1;
`else
  assign head_bit  = shreg[BUS_WIDTH-1];
  assign shreg_adv = shreg << 1;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      rem     <= '0;
      sel     <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      rem     <= rem_nx;
      sel     <= sel_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    rem_nx     = rem;
    sel_nx     = sel;
    // Abort wins over everything outside IDLE and freezes the select where it stands.
    if (sif.i_abort && (state != IDLE)) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sif.i_start) begin
            rem_nx   = sif.i_count;
            sel_nx   = sif.i_first_sel;
            state_nx = (sif.i_count == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          shreg_nx   = sif.i_slice;
          bit_cnt_nx = LAST_BIT;
          rem_nx     = rem - 1'b1;
          sel_nx     = sel + 1'b1;
          state_nx   = SHIFT;
        end
        SHIFT: begin
          if (sif.i_bit_ready) begin
            if (bit_cnt != '0) begin
              shreg_nx   = shreg_adv;
              bit_cnt_nx = bit_cnt - 1'b1;
            end else if (rem != '0) begin
              // The prefetched slice is already on i_slice, so reload without a bubble.
              shreg_nx   = sif.i_slice;
              bit_cnt_nx = LAST_BIT;
              rem_nx     = rem - 1'b1;
              sel_nx     = sel + 1'b1;
            end else begin
              state_nx = DONE;
            end
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign sif.o_ctrl_sel  = sel;
  assign sif.o_bit_valid = (state == SHIFT);
  assign sif.o_bit       = (state == SHIFT) & head_bit;
  assign sif.o_busy      = (state != IDLE);
  assign sif.o_done      = (state == DONE);
  assign sif.o_dbg_state = state;
endmodule

// File: tb/tb_hdr_slice_serializer.sv
// Bench for hdr_slice_serializer: vector table, hand sequences (abort, reset) and random runs
// checked against a slice-list reference model.
module tb_hdr_slice_serializer;
  localparam int W = 4;
  localparam int S = 5;
  localparam int N = 32;

  typedef logic [S-1:0] sel_t;
  typedef logic [S:0]   cnt_t;

  typedef struct {
    sel_t  first;
    cnt_t  count;
    int    mode;
    int    exp_bits;
    sel_t  exp_end;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] mux_mem [N];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  hdr_slice_serializer_if #(.BUS_WIDTH(W), .SEL(S)) bus ();

  hdr_slice_serializer #(.BUS_WIDTH(W), .SEL(S)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .sif       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign bus.i_slice = mux_mem[bus.o_ctrl_sel];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic next_ready(input int mode, input int acc, input int stall_given);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 2) return !(acc == 2 && stall_given < 3);
    return 1'b1;
  endfunction

  // driver + monitor for one transfer; abort_at/rst_at = accepted-bit index to interrupt at (-1: none)
  task automatic run_xfer(input string tag, input sel_t first, input cnt_t cnt, input int mode,
                          input int exp_bits, input sel_t exp_end, input int abort_at,
                          input int rst_at, output logic [31:0] bits_out);
    int acc = 0, stalls = 0, stall_given = 0, k, stop_kind = 0;
    bit held = 0, got_done = 0;
    logic hb, eb;
    sel_t hs;
    logic [W-1:0] s;
    bits_out = '0;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(mux_mem[(int'(first) + i) % N]);

    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_first_sel = first;
    bus.i_count = cnt;
    bus.i_bit_ready = next_ready(mode, acc, stall_given);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_first_sel = sel_t'($urandom);
    bus.i_count = cnt_t'($urandom_range(0, N));

    for (int cyc = 1; cyc <= 600 && !got_done && stop_kind == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, "_busy_rise"}, bus.o_busy, 1);
        check({tag, "_no_valid_load"}, bus.o_bit_valid, 0);
      end
      if (held) begin
        check({tag, "_hold_valid"}, bus.o_bit_valid, 1);
        check({tag, "_hold_bit"}, bus.o_bit, hb);
        check({tag, "_hold_sel"}, bus.o_ctrl_sel, hs);
      end
      held = 0;
      if (bus.o_done) begin
        got_done = 1;
        check({tag, "_bit_count"}, acc, exp_bits);
        check({tag, "_done_cycle"}, cyc, (cnt == 0) ? 1 : exp_bits + 2 + stalls);
        check({tag, "_end_sel"}, bus.o_ctrl_sel, exp_end);
        check({tag, "_done_no_valid"}, bus.o_bit_valid, 0);
      end else if (bus.o_bit_valid) begin
        check({tag, "_valid_cycle"}, cyc, acc + 2 + stalls);
        if (acc == abort_at) begin
          bus.i_abort = 1'b1;
          stop_kind = 1;
        end else if (acc == rst_at) begin
          rst_n = 1'b0;
          stop_kind = 2;
        end else begin
          k = acc / W;
          check({tag, "_sel"}, bus.o_ctrl_sel, sel_t'(int'(first) + k + 1));
          if (bus.i_bit_ready) begin
            if (k < exp_q.size()) begin
              s = exp_q[k];
`ifdef HDR_SER_LSB_FIRST_EN
              eb = s[acc % W];
`else
              eb = s[W - 1 - (acc % W)];
`endif
              check({tag, "_bit"}, bus.o_bit, eb);
            end else begin
              check({tag, "_extra_bit"}, acc, exp_bits);
            end
            bits_out = {bits_out[30:0], bus.o_bit};
            acc++;
          end else begin
            held = 1;
            hb = bus.o_bit;
            hs = bus.o_ctrl_sel;
            stalls++;
            stall_given++;
          end
        end
      end
      if (stop_kind == 0 && !got_done) begin
        @(posedge clk); #1;
        bus.i_bit_ready = next_ready(mode, acc, stall_given);
      end
    end

    if (stop_kind == 1) begin
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      @(negedge clk);
      check({tag, "_abort_valid"}, bus.o_bit_valid, 0);
      check({tag, "_abort_busy"}, bus.o_busy, 0);
      check({tag, "_abort_done"}, bus.o_done, 0);
      check({tag, "_abort_sel"}, bus.o_ctrl_sel, sel_t'(int'(first) + acc / W + 1));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({tag, "_abort_no_done"}, bus.o_done, 0);
      end
    end else if (stop_kind == 2) begin
      #1;
      check({tag, "_rst_sel"}, bus.o_ctrl_sel, 0);
      check({tag, "_rst_bit"}, bus.o_bit, 0);
      check({tag, "_rst_valid"}, bus.o_bit_valid, 0);
      check({tag, "_rst_busy"}, bus.o_busy, 0);
      check({tag, "_rst_done"}, bus.o_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({tag, "_post_rst_idle"}, bus.o_busy, 0);
      end
    end else begin
      check({tag, "_timeout"}, got_done, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.o_done, 0);
      check({tag, "_idle_after"}, bus.o_busy, 0);
    end
  endtask

  initial begin
    vec_t vecs [7];
    logic [31:0] bits;
    logic [31:0] basic_exp;
    sel_t f;
    cnt_t c;

`ifdef HDR_SER_LSB_FIRST_EN
    basic_exp = 32'hAF;
`else
    basic_exp = 32'h5F;
`endif
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_first_sel = '0;
    bus.i_count = '0;
    bus.i_bit_ready = 1'b0;
    for (int i = 0; i < N; i++) mux_mem[i] = W'($urandom);
    mux_mem[0] = 4'hA;
    mux_mem[1] = 4'h5;
    mux_mem[2] = 4'hF;
    mux_mem[3] = 4'h0;

    repeat (3) @(negedge clk);
    check("reset_sel", bus.o_ctrl_sel, 0);
    check("reset_bit", bus.o_bit, 0);
    check("reset_valid", bus.o_bit_valid, 0);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    rst_n = 1'b1;

    vecs[0] = '{sel_t'(1),  cnt_t'(2),  0, 8,   sel_t'(3)};
    vecs[1] = '{sel_t'(31), cnt_t'(2),  0, 8,   sel_t'(1)};
    vecs[2] = '{sel_t'(4),  cnt_t'(0),  0, 0,   sel_t'(4)};
    vecs[3] = '{sel_t'(1),  cnt_t'(2),  2, 8,   sel_t'(3)};
    vecs[4] = '{sel_t'(5),  cnt_t'(32), 0, 128, sel_t'(5)};
    vecs[5] = '{sel_t'(7),  cnt_t'(3),  1, 12,  sel_t'(10)};
    vecs[6] = '{sel_t'(30), cnt_t'(5),  1, 20,  sel_t'(3)};
    for (int v = 0; v < 7; v++) begin
      run_xfer($sformatf("vec%0d", v), vecs[v].first, vecs[v].count, vecs[v].mode,
               vecs[v].exp_bits, vecs[v].exp_end, -1, -1, bits);
      if (v == 0 || v == 3) check($sformatf("vec%0d_stream", v), bits, basic_exp);
    end

    run_xfer("abort", sel_t'(1), cnt_t'(2), 0, 8, sel_t'(3), 2, -1, bits);
    run_xfer("restart", sel_t'(1), cnt_t'(2), 0, 8, sel_t'(3), -1, -1, bits);
    check("restart_stream", bits, basic_exp);
    run_xfer("rst", sel_t'(1), cnt_t'(2), 0, 8, sel_t'(3), -1, 2, bits);
    run_xfer("post_rst", sel_t'(1), cnt_t'(2), 0, 8, sel_t'(3), -1, -1, bits);
    check("post_rst_stream", bits, basic_exp);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) mux_mem[i] = W'($urandom);
      f = sel_t'($urandom);
      c = cnt_t'($urandom_range(1, 6));
      run_xfer($sformatf("rand%0d", r), f, c, 1, int'(c) * W,
               sel_t'(int'(f) + int'(c)), -1, -1, bits);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdr_slice_serializer.md
# hdr_slice_serializer

- Sequencing stage placed directly in front of the HDR_TOP generic slice mux.
- Drives the mux `ctrl_sel` through a programmed run of consecutive slices and captures each `BUS_WIDTH`-bit slice the mux returns.
- Shifts each captured slice out one bit at a time under a per-bit ready handshake, gapless across slice boundaries.
- Reports busy and done status to the HDR engine FSM.

## Interface
- `BUS_WIDTH`, 4: slice width; must equal the mux `BUS_WIDTH`.
- `SEL`, 5: mux select width; 2**SEL slices addressable.
- `i_sys_clk`  in  1  system clock; all state updates on rising edge.
- `i_sys_rst`  in  1  reset, asynchronous and active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_abort`  in  1  synchronous abort; returns to IDLE, no done pulse.
- `i_first_sel`  in  SEL  index of first slice; latched on accepted start.
- `i_count`  in  SEL+1  number of slices, 0..2**SEL; latched on accepted start.
- `i_slice`  in  BUS_WIDTH  slice from the mux `data_out`; combinational from `o_ctrl_sel`.
- `i_bit_ready`  in  1  downstream accepts the current bit this cycle.
- `o_ctrl_sel`  out  SEL  registered select to the mux.
- `o_bit`  out  1  current serial bit.
- `o_bit_valid`  out  1  `o_bit` is valid.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse after the last bit of the last slice is accepted.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE, `i_start`=1:
  - Latch `i_count` into `rem`.
  - `o_ctrl_sel` <= `i_first_sel`.
  - `i_count`==0 → DONE; otherwise → LOAD.
- LOAD:
  - `shreg` <= `i_slice`; `bit_cnt` <= BUS_WIDTH-1; `rem` <= `rem`-1.
  - `o_ctrl_sel` <= `o_ctrl_sel`+1 (prefetch next slice).
  - → SHIFT.
- SHIFT: `o_bit_valid`=1, `o_bit` = `shreg` MSB.
  - `i_bit_ready`=1 and `bit_cnt`≠0: shift left, `bit_cnt`--.
  - `i_bit_ready`=1, `bit_cnt`==0, `rem`≠0: reload `shreg` from `i_slice` in the same edge; `bit_cnt` <= BUS_WIDTH-1; `rem`--; `o_ctrl_sel`++. Stay in SHIFT, no bubble.
  - `i_bit_ready`=1, `bit_cnt`==0, `rem`==0: → DONE.
  - `i_bit_ready`=0: hold all state; `o_bit` and `o_bit_valid` stable.
- DONE: `o_done`=1 for exactly one cycle → IDLE.
- `i_abort` in LOAD, SHIFT or DONE:
  - → IDLE next edge.
  - `o_bit_valid` and `o_done` low from that edge.
  - `o_ctrl_sel` holds its last value.
  - Abort has priority over every other transition.
- `i_start` outside IDLE is ignored.
- `o_ctrl_sel` increments modulo 2**SEL. A run from `i_first_sel`=2**SEL-1 continues at 0.
- `i_count`=2**SEL visits every slice exactly once.

## Timing
- Reset values:
  - All outputs: `o_ctrl_sel`=0, `o_bit`=0, `o_bit_valid`=0, `o_busy`=0, `o_done`=0.
  - Internal: `shreg`=0, `bit_cnt`=0, `rem`=0; state IDLE.
- Start sampled at edge N → LOAD during cycle N+1 → first `o_bit_valid` in cycle N+2. `o_busy` rises from edge N.
- With `i_bit_ready` held high, a run of `i_count` slices produces `i_count`*BUS_WIDTH consecutive valid cycles, then `o_done` in the following cycle.
- `i_slice` must settle within one cycle of an `o_ctrl_sel` change. The mux is purely combinational, so no extra wait state exists.
- Reset asserted mid-run clears everything immediately. Nothing resumes after release.

## Configuration
- `HDR_SER_LSB_FIRST_EN`:
  - Defined: `o_bit` = `shreg` LSB; shift right.
  - Undefined (default): MSB first, shift left.
- Slice order, counts and timing are identical in both builds.

## Test plan
- Basic run: BUS_WIDTH=4, mux slices 0..3 = 4'hA,4'h5,4'hF,4'h0; `i_first_sel`=1, `i_count`=2, ready high → bits 0101 1111, `o_done` exactly 1 cycle after the 8th valid bit; `o_ctrl_sel` sequence 1,2,3.
- Wrap: `i_first_sel`=31, `i_count`=2 → slices 31 then 0, gapless across the boundary.
- Backpressure: `i_bit_ready` low for 3 cycles on bit 2 of slice 0 → `o_bit` and `o_ctrl_sel` stable; stream resumes with no lost or duplicated bit.
- Zero count: `i_count`=0 → `o_bit_valid` never high; `o_done` 1 cycle after start; `o_busy` high for exactly 1 cycle.
- Abort and restart: `i_abort` at the 3rd valid bit → IDLE next cycle, no `o_done`. A new start 1 cycle later runs a full transfer correctly. Same stimulus with `i_sys_rst` low mid-run → all outputs 0 immediately.
- LSB-first build: basic run with `HDR_SER_LSB_FIRST_EN` defined → bits 1010 1111.
